// File: rtl/fpadd.sv
// rtl/fpadd.sv - multi-cycle IEEE 754 binary16 adder (IDLE/ALIGN/ADD/NORM/ROUND)
module fpadd (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    output logic [15:0] y,
    output logic        ready
);
    typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

    state_t             state_q, state_d;
    logic [15:0]        a_q, a_d, b_q, b_d;
    logic               sign_q, sign_d;
    logic               sub_q, sub_d;
    logic signed [6:0]  exp_q, exp_d;
    logic [14:0]        acc_q, acc_d;
    logic [13:0]        sml_q, sml_d;
    logic               spec_q, spec_d;
    logic [15:0]        spec_val_q, spec_val_d;
    logic               zero_q, zero_d;
    logic [15:0]        y_q, y_d;
    logic               ready_q, ready_d;

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] n;
        n = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (v[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

    logic [4:0]         ea, eb, e_l, e_s, e_diff;
    logic [10:0]        ma, mb, m_l, m_s;
    logic               a_nan, b_nan, a_inf, b_inf, a_big;
    logic [27:0]        sh_wide;
    logic [13:0]        sh_sig;

    // Subnormals are treated as zero, so they get a zero significand and magnitude key.
    assign ea     = a_q[14:10];
    assign eb     = b_q[14:10];
    assign ma     = (ea == 5'd0) ? 11'd0 : {1'b1, a_q[9:0]};
    assign mb     = (eb == 5'd0) ? 11'd0 : {1'b1, b_q[9:0]};
    assign a_nan  = (&ea) & (|a_q[9:0]);
    assign b_nan  = (&eb) & (|b_q[9:0]);
    assign a_inf  = (&ea) & ~(|a_q[9:0]);
    assign b_inf  = (&eb) & ~(|b_q[9:0]);
    assign a_big  = ((ea == 5'd0) ? 15'd0 : a_q[14:0]) >= ((eb == 5'd0) ? 15'd0 : b_q[14:0]);
    assign e_l    = a_big ? ea : eb;
    assign e_s    = a_big ? eb : ea;
    assign m_l    = a_big ? ma : mb;
    assign m_s    = a_big ? mb : ma;
    assign e_diff = e_l - e_s;
    assign sh_wide = {m_s, 17'd0} >> e_diff;
    assign sh_sig  = (e_diff > 5'd13) ? {13'd0, |m_s} : {sh_wide[27:15], |sh_wide[14:0]};

    logic [14:0]        sum;
    assign sum = sub_q ? (acc_q - {1'b0, sml_q}) : (acc_q + {1'b0, sml_q});

    logic [3:0]         lz;
    logic [13:0]        norm_sig;
    logic signed [6:0]  norm_exp;
    assign lz       = lzc14(acc_q[13:0]);
    assign norm_sig = acc_q[14] ? {acc_q[14:2], |acc_q[1:0]} : (acc_q[13:0] << lz);
    assign norm_exp = acc_q[14] ? (exp_q + 7'sd1) : (exp_q - $signed({3'b000, lz}));

    // Normalised layout: bit13 hidden one, bits 12:3 fraction, bits 2:0 guard/round/sticky.
    logic               rnd_up;
    logic [10:0]        rnd_frac;
    logic signed [6:0]  rnd_exp;
    logic [15:0]        rnd_y;
    assign rnd_up   = acc_q[2] & (acc_q[3] | acc_q[1] | acc_q[0]);
    assign rnd_frac = {1'b0, acc_q[12:3]} + {10'd0, rnd_up};
    assign rnd_exp  = rnd_frac[10] ? (exp_q + 7'sd1) : exp_q;

    always_comb begin
        rnd_y = {sign_q, rnd_exp[4:0], rnd_frac[9:0]};
        if (spec_q) begin
            rnd_y = spec_val_q;
        end else if (zero_q) begin
            rnd_y = {sign_q & ~sub_q, 15'd0};
        end else if (rnd_exp <= 7'sd0) begin
            rnd_y = {sign_q, 15'd0};
        end else if (rnd_exp >= 7'sd31) begin
            rnd_y = {sign_q, 5'h1F, 10'd0};
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        sign_d     = sign_q;
        sub_d      = sub_q;
        exp_d      = exp_q;
        acc_d      = acc_q;
        sml_d      = sml_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        zero_d     = zero_q;
        y_d        = y_q;
        ready_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    a_d     = x1;
                    b_d     = x2;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                sign_d  = a_big ? a_q[15] : b_q[15];
                sub_d   = a_q[15] ^ b_q[15];
                exp_d   = $signed({2'b00, e_l});
                acc_d   = {1'b0, m_l, 3'b000};
                sml_d   = sh_sig;
                spec_d  = a_nan | b_nan | a_inf | b_inf;
                if (a_nan | b_nan | (a_inf & b_inf & (a_q[15] ^ b_q[15]))) begin
                    spec_val_d = 16'h7E00;
                end else if (a_inf) begin
                    spec_val_d = a_q;
                end else begin
                    spec_val_d = b_q;
                end
                state_d = ADD;
            end
            ADD: begin
                acc_d   = sum;
                state_d = NORM;
            end
            NORM: begin
                acc_d   = {1'b0, norm_sig};
                exp_d   = norm_exp;
                zero_d  = (acc_q == 15'd0);
                state_d = ROUND;
            end
            ROUND: begin
                y_d     = rnd_y;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            a_q        <= 16'd0;
            b_q        <= 16'd0;
            sign_q     <= 1'b0;
            sub_q      <= 1'b0;
            exp_q      <= 7'sd0;
            acc_q      <= 15'd0;
            sml_q      <= 14'd0;
            spec_q     <= 1'b0;
            spec_val_q <= 16'd0;
            zero_q     <= 1'b0;
            y_q        <= 16'd0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sign_q     <= sign_d;
            sub_q      <= sub_d;
            exp_q      <= exp_d;
            acc_q      <= acc_d;
            sml_q      <= sml_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            zero_q     <= zero_d;
            y_q        <= y_d;
            ready_q    <= ready_d;
        end
    end

    assign y     = y_q;
    assign ready = ready_q;
endmodule

// File: tb/tb_fpadd.sv
// tb/tb_fpadd.sv - self-checking bench for the binary16 adder fpadd
module tb_fpadd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [15:0] x1  = 16'd0;
    logic [15:0] x2  = 16'd0;
    logic [15:0] y;
    logic        ready;
    int          checks = 0;
    int          errors = 0;

    fpadd dut (.clk(clk), .rst(rst), .en(en), .x1(x1), .x2(x2), .y(y), .ready(ready));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
        end
    endtask

    // Exact sum in units of 2^-24, then round-to-nearest-even to binary16.
    function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
        longint va, vb, s, m, q, rem, half;
        int     p, fe, sh;
        logic   sn;
        if ((a[14:10] == 5'h1F && a[9:0] != 0) || (b[14:10] == 5'h1F && b[9:0] != 0)) return 16'h7E00;
        if (a[14:10] == 5'h1F && b[14:10] == 5'h1F) return (a[15] == b[15]) ? a : 16'h7E00;
        if (a[14:10] == 5'h1F) return a;
        if (b[14:10] == 5'h1F) return b;
        va = (a[14:10] == 0) ? 64'sd0 : (longint'({1'b1, a[9:0]}) << (a[14:10] - 1));
        vb = (b[14:10] == 0) ? 64'sd0 : (longint'({1'b1, b[9:0]}) << (b[14:10] - 1));
        if (a[15]) va = -va;
        if (b[15]) vb = -vb;
        s = va + vb;
        if (s == 0) return {a[15] & b[15], 15'd0};
        sn = (s < 0);
        m  = sn ? -s : s;
        p  = 0;
        for (int i = 0; i < 63; i++) if (m[i]) p = i;
        fe = p - 9;
        sh = p - 10;
        if (sh > 0) begin
            q    = m >> sh;
            rem  = m - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q = q + 1;
            if (q == 2048) begin
                q  = 1024;
                fe = fe + 1;
            end
        end else begin
            q = m << (-sh);
        end
        if (fe <= 0) return {sn, 15'd0};
        if (fe >= 31) return {sn, 5'h1F, 10'd0};
        return {sn, fe[4:0], q[9:0]};
    endfunction

    // Transaction-level model: an accepted request yields its sum four edges later.
    int          m_cnt = 0;
    logic [15:0] m_pend = 16'd0;
    logic [15:0] m_y = 16'd0;
    logic        m_ready = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt   <= 0;
            m_y     <= 16'd0;
            m_ready <= 1'b0;
        end else begin
            m_ready <= 1'b0;
            if (m_cnt > 1) begin
                m_cnt <= m_cnt - 1;
            end else if (m_cnt == 1) begin
                m_cnt   <= 0;
                m_ready <= 1'b1;
                m_y     <= m_pend;
            end else if (en) begin
                m_pend <= ref_add(x1, x2);
                m_cnt  <= 4;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("cycle ready", {15'd0, ready}, {15'd0, m_ready});
        check("cycle y", y, m_y);
    end

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        @(negedge clk);
        x1 = a;
        x2 = b;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        x1 = ~a;
        x2 = ~b;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic directed(input logic [15:0] a, input logic [15:0] b, input logic [15:0] want,
                            input string name);
        int lat;
        check({name, " model"}, ref_add(a, b), want);
        run_op(a, b, lat);
        check({name, " latency"}, 16'(lat), 16'd4);
        check({name, " y"}, y, want);
    endtask

    function automatic logic [15:0] rand_normal();
        return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom)};
    endfunction

    function automatic logic [15:0] rand_near(input logic [15:0] a);
        int e;
        e = int'(a[14:10]) + int'($urandom_range(0, 4)) - 2;
        if (e < 1) e = 1;
        if (e > 30) e = 30;
        return {1'($urandom_range(0, 1)), 5'(e), 10'($urandom)};
    endfunction

    initial begin
        #1500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        int          lat;
        #2 rst = 1'b0;
        #1;
        check("reset y", y, 16'h0000);
        check("reset ready", {15'd0, ready}, 16'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        directed(16'h3C00, 16'h3C00, 16'h4000, "1+1");
        directed(16'h3C00, 16'hBC00, 16'h0000, "1-1");
        directed(16'h3C00, 16'h1000, 16'h3C00, "tie even");
        directed(16'h3C01, 16'h1000, 16'h3C02, "tie odd");
        directed(16'h3C00, 16'h0400, 16'h3C00, "far shift");
        directed(16'h3FFF, 16'h1000, 16'h4000, "round carry");
        directed(16'h7BFF, 16'h7BFF, 16'h7C00, "overflow");
        directed(16'h7BFF, 16'h5000, 16'h7C00, "round overflow");
        directed(16'h7C00, 16'hFC00, 16'h7E00, "inf-inf");
        directed(16'h7C01, 16'h3C00, 16'h7E00, "nan in");
        directed(16'h8000, 16'h8000, 16'h8000, "-0+-0");
        directed(16'hFC00, 16'hFC00, 16'hFC00, "ninf+ninf");
        directed(16'h3C00, 16'h7C00, 16'h7C00, "fin+inf");
        directed(16'h3C00, 16'h0001, 16'h3C00, "subnormal in");
        directed(16'h8401, 16'h0400, 16'h8000, "flush sign");

        @(negedge clk);
        x1 = 16'h4000;
        x2 = 16'h3C00;
        en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("held en ready edge %0d", i), {15'd0, ready}, {15'd0, (i == 4 || i == 9)});
            if (i == 4) check("held en y", y, 16'h4200);
        end
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(posedge clk);

        @(negedge clk);
        x1 = 16'h4000;
        x2 = 16'h4000;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        x1 = 16'h3C00;
        repeat (4) @(posedge clk);
        #1;
        check("captured x1 ready", {15'd0, ready}, 16'd1);
        check("captured x1 y", y, 16'h4400);

        @(negedge clk);
        x1 = 16'h3C00;
        x2 = 16'h3C00;
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en  = 1'b0;
        rst = 1'b0;
        #1;
        check("abort y", y, 16'h0000);
        check("abort ready", {15'd0, ready}, 16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort no ready %0d", i), {15'd0, ready}, 16'd0);
        end
        directed(16'h4000, 16'hBC00, 16'h3C00, "after reset");

        for (int n = 0; n < 10000; n++) begin
            ra = rand_normal();
            rb = (n % 2 == 0) ? rand_normal() : rand_near(ra);
            run_op(ra, rb, lat);
            check("random latency", 16'(lat), 16'd4);
        end

        repeat (2) @(posedge clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
